sevenseg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment display controller: accepts a binary value through a valid/ready handshake, converts it serially to BCD (or passes it as hex), and time-multiplexes DIGITS common-anode digits with per-digit decimal points. It replaces fixed 4-digit, combinational-divide display logic on the 100 MHz board clock domain and sits directly in front of the anode/cathode pins.

---
 rtl/sevenseg_pkg.sv | 65 ++++++
 rtl/bin2bcd_serial.sv | 78 +++++++
 rtl/sevenseg_scan_display.sv | 221 ++++++++++++++++++++++
 tb/tb_sevenseg_scan_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared definitions for the multiplexed seven-segment display controller:
//   active-low segment glyphs (order {a,b,c,d,e,f,g}, a = MSB), the glyph
//   lookup function, a power-of-ten helper used for decimal range checks,
//   and the conversion FSM state type.
package sevenseg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } conv_state_t;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
      case (nibble)
         4'h0:    seg_glyph = SEG_0;
         4'h1:    seg_glyph = SEG_1;
         4'h2:    seg_glyph = SEG_2;
         4'h3:    seg_glyph = SEG_3;
         4'h4:    seg_glyph = SEG_4;
         4'h5:    seg_glyph = SEG_5;
         4'h6:    seg_glyph = SEG_6;
         4'h7:    seg_glyph = SEG_7;
         4'h8:    seg_glyph = SEG_8;
         4'h9:    seg_glyph = SEG_9;
         4'hA:    seg_glyph = SEG_A;
         4'hB:    seg_glyph = SEG_B;
         4'hC:    seg_glyph = SEG_C;
         4'hD:    seg_glyph = SEG_D;
         4'hE:    seg_glyph = SEG_E;
         4'hF:    seg_glyph = SEG_F;
         default: seg_glyph = SEG_DASH;
      endcase
   endfunction

   // Largest value representable in n decimal digits, in 64-bit arithmetic.
   function automatic logic [63:0] pow10_minus1(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
//   Serial double-dabble binary-to-BCD converter, one input bit per cycle,
//   MSB first. A start pulse loads the value; VALUE_W shift cycles follow.
// Ports:
//   clock_100Mhz  system clock
//   reset         async active-high reset
//   start         load value_in and begin converting
//   value_in      binary value to convert (VALUE_W bits)
//   busy          conversion in progress
//   done          final shift happens on the coming edge; bcd holds the
//                 result from that edge until the next start
//   bcd           BCD result, 4*DIGITS bits, digit 0 in the low nibble
module bin2bcd_serial
   import sevenseg_pkg::*;
#(
   parameter int VALUE_W = 16,
   parameter int DIGITS  = 4
) (
   input  logic                  clock_100Mhz,
   input  logic                  reset,
   input  logic                  start,
   input  logic [VALUE_W-1:0]    value_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] shift_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [BCD_W-1:0]   adj_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic               done_s;

   // Add-3 correction: every nibble >= 5 gets +3 before it is shifted.
   always_comb begin
      adj_s = bcd_r;
      for (int n = 0; n < DIGITS; n++) begin
         if (bcd_r[4*n +: 4] >= 4'd5) begin
            adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
         end else begin
            adj_s[4*n +: 4] = bcd_r[4*n +: 4];
         end
      end
   end

   assign done_s = busy_r && (cnt_r == CNT_W'(VALUE_W - 1));

   // Load on start, then shift one binary bit into the BCD register per cycle.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         shift_r <= {VALUE_W{1'b0}};
         bcd_r   <= {BCD_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
      end else if (start) begin
         shift_r <= value_in;
         bcd_r   <= {BCD_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b1;
      end else if (busy_r) begin
         bcd_r   <= {adj_s[BCD_W-2:0], shift_r[VALUE_W-1]};
         shift_r <= {shift_r[VALUE_W-2:0], 1'b0};
         cnt_r   <= cnt_r + CNT_W'(1);
         if (done_s) begin
            busy_r <= 1'b0;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_s;
   assign bcd  = bcd_r;

endmodule

// File: rtl/sevenseg_scan_display.sv
// sevenseg_scan_display
//   Multiplexed common-anode seven-segment controller. Accepts a binary value
//   over value_valid/value_ready, converts it serially to BCD (or takes it as
//   hex), commits it atomically to a display register and scans DIGITS digits,
//   one every CLK_HZ/DIGIT_HZ cycles. All pin outputs are registered.
// Optional build macro:
//   SEVENSEG_LEADING_ZERO_BLANK_EN - blank zero digits above the most
//   significant nonzero digit (digit 0 and overflow dashes never blanked).
// Ports:
//   clock_100Mhz    system clock
//   reset           async active-high reset
//   value_valid     new value offered
//   value           binary value, sampled on handshake
//   hex_mode        1 = hex, 0 = decimal, sampled on handshake
//   dp              decimal-point enables per digit, sampled on handshake
//   value_ready     block can accept a value
//   overflow        committed value does not fit in DIGITS digits
//   Anode_Activate  active-low anodes, bit 0 = rightmost digit
//   LED_out         active-low cathodes {a,b,c,d,e,f,g}
//   dp_out          active-low decimal-point cathode
module sevenseg_scan_display
   import sevenseg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int VALUE_W  = 16,
   parameter int CLK_HZ   = 100_000_000,
   parameter int DIGIT_HZ = 1520
) (
   input  logic                clock_100Mhz,
   input  logic                reset,
   input  logic                value_valid,
   input  logic [VALUE_W-1:0]  value,
   input  logic                hex_mode,
   input  logic [DIGITS-1:0]   dp,
   output logic                value_ready,
   output logic                overflow,
   output logic [DIGITS-1:0]   Anode_Activate,
   output logic [6:0]          LED_out,
   output logic                dp_out
);

   localparam int PRE_RAW = CLK_HZ / DIGIT_HZ;
   localparam int PRE     = (PRE_RAW < 1) ? 1 : PRE_RAW;
   localparam int PRE_W   = (PRE > 1) ? $clog2(PRE) : 1;
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCD_W   = 4 * DIGITS;
   localparam logic [63:0] DEC_MAX = pow10_minus1(DIGITS);

   conv_state_t        state_r, state_next_s;
   logic               ready_r;
   logic               xfer_s;
   logic [63:0]        value_ext_s;
   logic               ovf_in_s;
   logic               conv_busy_s, conv_done_s;
   logic [BCD_W-1:0]   conv_bcd_s;

   logic               pend_hex_r, pend_ovf_r;
   logic [DIGITS-1:0]  pend_dp_r;
   logic [BCD_W-1:0]   pend_nib_r;

   logic               disp_hex_r, disp_ovf_r;
   logic [DIGITS-1:0]  disp_dp_r;
   logic [BCD_W-1:0]   disp_nib_r;

   logic [PRE_W-1:0]   pre_r;
   logic [IDX_W-1:0]   idx_r;
   logic [3:0]         nib_s;
   logic               blank_s;
   logic [6:0]         glyph_s;
   logic [DIGITS-1:0]  anode_s;

   assign xfer_s      = value_valid && ready_r;
   assign value_ext_s = 64'(value);
   assign ovf_in_s    = hex_mode ? ((value_ext_s >> (4 * DIGITS)) != 64'd0)
                                 : (value_ext_s > DEC_MAX);

   bin2bcd_serial #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_bin2bcd (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .start        (xfer_s && !hex_mode),
      .value_in     (value),
      .busy         (conv_busy_s),
      .done         (conv_done_s),
      .bcd          (conv_bcd_s)
   );

   // Conversion FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (xfer_s) begin
               state_next_s = hex_mode ? COMMIT : CONVERT;
            end else begin
               state_next_s = IDLE;
            end
         end
         CONVERT: begin
            if (conv_done_s) begin
               state_next_s = COMMIT;
            end else if (!conv_busy_s) begin
               // Converter lost its job; recover rather than wait forever.
               state_next_s = IDLE;
            end else begin
               state_next_s = CONVERT;
            end
         end
         COMMIT:  state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM state and registered ready flag (ready exactly while IDLE).
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_next_s;
         ready_r <= (state_next_s == IDLE);
      end
   end

   // Capture handshake-time attributes until the value is committed.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         pend_hex_r <= 1'b0;
         pend_ovf_r <= 1'b0;
         pend_dp_r  <= {DIGITS{1'b0}};
         pend_nib_r <= {BCD_W{1'b0}};
      end else if (xfer_s) begin
         pend_hex_r <= hex_mode;
         pend_ovf_r <= ovf_in_s;
         pend_dp_r  <= dp;
         pend_nib_r <= value_ext_s[BCD_W-1:0];
      end
   end

   // Display register: swapped atomically in COMMIT so scanning never tears.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         disp_hex_r <= 1'b0;
         disp_ovf_r <= 1'b0;
         disp_dp_r  <= {DIGITS{1'b0}};
         disp_nib_r <= {BCD_W{1'b0}};
      end else if (state_r == COMMIT) begin
         disp_hex_r <= pend_hex_r;
         disp_ovf_r <= pend_ovf_r;
         disp_dp_r  <= pend_dp_r;
         disp_nib_r <= pend_hex_r ? pend_nib_r : conv_bcd_s;
      end
   end

   // Dwell prescaler and digit index.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         pre_r <= {PRE_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
      end else if (pre_r == PRE_W'(PRE - 1)) begin
         pre_r <= {PRE_W{1'b0}};
         if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_r <= {IDX_W{1'b0}};
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         pre_r <= pre_r + PRE_W'(1);
      end
   end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lead_zero_s;
   logic              zero_run_s;

   // lead_zero_s[i] is set when digits i..DIGITS-1 are all zero.
   always_comb begin
      lead_zero_s = {DIGITS{1'b0}};
      zero_run_s  = 1'b1;
      for (int n = DIGITS - 1; n >= 0; n--) begin
         zero_run_s     = zero_run_s && (disp_nib_r[4*n +: 4] == 4'd0);
         lead_zero_s[n] = zero_run_s;
      end
   end

   assign blank_s = lead_zero_s[idx_r] && (idx_r != IDX_W'(0));
`else
   assign blank_s = 1'b0;
`endif

   // Glyph and anode selection for the digit currently being scanned.
   always_comb begin
      nib_s = disp_nib_r[{idx_r, 2'b00} +: 4];
      if (disp_ovf_r) begin
         glyph_s = SEG_DASH;
      end else if (blank_s) begin
         glyph_s = SEG_BLANK;
      end else if (!disp_hex_r && (nib_s > 4'd9)) begin
         glyph_s = SEG_DASH;
      end else begin
         glyph_s = seg_glyph(nib_s);
      end
      anode_s = ~(DIGITS'(1'b1) << idx_r);
   end

   // Registered pin drivers; all off during reset.
   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         Anode_Activate <= {DIGITS{1'b1}};
         LED_out        <= SEG_BLANK;
         dp_out         <= 1'b1;
      end else begin
         Anode_Activate <= anode_s;
         LED_out        <= glyph_s;
         dp_out         <= ~disp_dp_r[idx_r];
      end
   end

   assign value_ready = ready_r;
   assign overflow    = disp_ovf_r;

endmodule

// File: tb/tb_sevenseg_scan_display.sv
module tb_sevenseg_scan_display;

   logic        clock_100Mhz = 1'b0;
   logic        reset;
   logic        value_valid;
   logic [15:0] value;
   logic        hex_mode;
   logic [3:0]  dp;
   logic        value_ready;
   logic        overflow;
   logic [3:0]  Anode_Activate;
   logic [6:0]  LED_out;
   logic        dp_out;

   always #5 clock_100Mhz = ~clock_100Mhz;

   sevenseg_scan_display #(
      .DIGITS(4), .VALUE_W(16), .CLK_HZ(4), .DIGIT_HZ(1)
   ) dut (
      .clock_100Mhz   (clock_100Mhz),
      .reset          (reset),
      .value_valid    (value_valid),
      .value          (value),
      .hex_mode       (hex_mode),
      .dp             (dp),
      .value_ready    (value_ready),
      .overflow       (overflow),
      .Anode_Activate (Anode_Activate),
      .LED_out        (LED_out),
      .dp_out         (dp_out)
   );

   typedef struct {
      logic [3:0] anode;
      logic [6:0] led;
      logic       dpo;
      logic       ovf;
      int         dwell;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
   localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0000100, GB = 7'b1100000, GE = 7'b0110000;
   localparam logic [6:0] GF = 7'b0111000, GDASH = 7'b1111110, GOFF = 7'b1111111;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Monitor: each time a new digit is presented, compare against the queue head.
   initial begin : monitor
      logic [3:0] prev_anode;
      int         since;
      exp_t       e;
      prev_anode = 4'b1111;
      since      = 0;
      forever begin
         @(negedge clock_100Mhz);
         if (Anode_Activate !== prev_anode) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("scan_anode", 32'(Anode_Activate), 32'(e.anode));
               check("scan_led", 32'(LED_out), 32'(e.led));
               check("scan_dp", 32'(dp_out), 32'(e.dpo));
               check("scan_ovf", 32'(overflow), 32'(e.ovf));
               if (e.dwell != 0) check("scan_dwell", since, e.dwell);
            end
            since = 1;
         end else begin
            since = since + 1;
         end
         prev_anode = Anode_Activate;
      end
   end

   task automatic push_scan(input logic [6:0] l0, input logic [6:0] l1, input logic [6:0] l2,
                            input logic [6:0] l3, input logic [3:0] dpv, input logic ovf,
                            input logic first_free);
      logic [6:0] leds [4];
      exp_t       e;
      leds[0] = l0; leds[1] = l1; leds[2] = l2; leds[3] = l3;
      for (int i = 0; i < 4; i++) begin
         e.anode = ~(4'b0001 << i);
         e.led   = leds[i];
         e.dpo   = ~dpv[i];
         e.ovf   = ovf;
         e.dwell = (first_free && i == 0) ? 0 : 4;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain(input string nm);
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock_100Mhz);
      end
      check(nm, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Align to digit 3 so the next four presented digits are 0..3.
   task automatic sync_digit3();
      for (int k = 0; k < 100; k++) begin
         @(negedge clock_100Mhz);
         if (Anode_Activate === 4'b0111) break;
      end
      check("sync_digit3", 32'(Anode_Activate), 32'(4'b0111));
      #1;
   endtask

   task automatic send(input logic [15:0] v, input logic hx, input logic [3:0] dv,
                       input int hold, input int exp_low, input string nm);
      int lows;
      @(negedge clock_100Mhz);
      value = v; hex_mode = hx; dp = dv; value_valid = 1'b1;
      @(posedge clock_100Mhz);
      #1;
      lows = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock_100Mhz);
         if (value_ready) break;
         lows++;
         if (k < hold) value = value + 16'd1111;
         else value_valid = 1'b0;
      end
      value_valid = 1'b0;
      check(nm, lows, exp_low);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stimulus
      reset = 1'b1; value_valid = 1'b0; value = 16'd0; hex_mode = 1'b0; dp = 4'b0000;
      repeat (3) @(negedge clock_100Mhz);
      check("rst_anode", 32'(Anode_Activate), 32'(4'b1111));
      check("rst_led", 32'(LED_out), 32'(7'b1111111));
      check("rst_dp", 32'(dp_out), 32'(1'b1));
      check("rst_ready", 32'(value_ready), 32'(1'b1));
      check("rst_ovf", 32'(overflow), 32'(1'b0));
      push_scan(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b1);
      reset = 1'b0;
      wait_drain("drain_reset");

      send(16'd1234, 1'b0, 4'b0000, 0, 17, "ready_low_1234");
      sync_digit3();
      push_scan(G4, G3, G2, G1, 4'b0000, 1'b0, 1'b0);
      wait_drain("drain_1234");

      send(16'd10000, 1'b0, 4'b0000, 0, 17, "ready_low_10000");
      sync_digit3();
      push_scan(GDASH, GDASH, GDASH, GDASH, 4'b0000, 1'b1, 1'b0);
      wait_drain("drain_10000");

      send(16'd9999, 1'b0, 4'b0000, 0, 17, "ready_low_9999");
      sync_digit3();
      push_scan(G9, G9, G9, G9, 4'b0000, 1'b0, 1'b0);
      wait_drain("drain_9999");

      send(16'hBEEF, 1'b1, 4'b0100, 0, 1, "ready_low_hex");
      sync_digit3();
      push_scan(GF, GE, GE, GB, 4'b0100, 1'b0, 1'b0);
      wait_drain("drain_hex");

      send(16'd5678, 1'b0, 4'b0000, 8, 17, "ready_low_hold");
      sync_digit3();
      push_scan(G8, G7, G6, G5, 4'b0000, 1'b0, 1'b0);
      wait_drain("drain_hold");

      send(16'd7, 1'b0, 4'b1000, 0, 17, "ready_low_7");
      sync_digit3();
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      push_scan(G7, GOFF, GOFF, GOFF, 4'b1000, 1'b0, 1'b0);
`else
      push_scan(G7, G0, G0, G0, 4'b1000, 1'b0, 1'b0);
`endif
      wait_drain("drain_7");

      send(16'd0, 1'b0, 4'b0000, 0, 17, "ready_low_0");
      sync_digit3();
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      push_scan(G0, GOFF, GOFF, GOFF, 4'b0000, 1'b0, 1'b0);
`else
      push_scan(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b0);
`endif
      wait_drain("drain_0");

      send(16'd12345, 1'b0, 4'b0000, 0, 17, "ready_low_12345");
      sync_digit3();
      push_scan(GDASH, GDASH, GDASH, GDASH, 4'b0000, 1'b1, 1'b0);
      wait_drain("drain_12345");

      // Start a conversion and abort it with reset part-way through.
      @(negedge clock_100Mhz);
      value = 16'd4321; hex_mode = 1'b0; dp = 4'b1111; value_valid = 1'b1;
      @(posedge clock_100Mhz);
      #1 value_valid = 1'b0;
      check("mid_ready_low", 32'(value_ready), 32'(1'b0));
      repeat (5) @(negedge clock_100Mhz);
      #2 reset = 1'b1;
      #1;
      check("abort_anode", 32'(Anode_Activate), 32'(4'b1111));
      check("abort_led", 32'(LED_out), 32'(7'b1111111));
      check("abort_dp", 32'(dp_out), 32'(1'b1));
      check("abort_ready", 32'(value_ready), 32'(1'b1));
      check("abort_ovf", 32'(overflow), 32'(1'b0));
      @(negedge clock_100Mhz);
      @(negedge clock_100Mhz);
      push_scan(G0, G0, G0, G0, 4'b0000, 1'b0, 1'b1);
      reset = 1'b0;
      wait_drain("drain_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
